// File: rtl/audio_pkg.sv
// audio_pkg: shared scheduler state type and default sample width
package audio_pkg;
  localparam int AUDIO_DATA_WIDTH = 32;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_L = 3'd1,
    ISSUE_R = 3'd2,
    WAIT_L  = 3'd3,
    WAIT_R  = 3'd4,
    DONE    = 3'd5
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             increment,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;
  // bump unless already saturated
  always_comb count_d = (increment && !(&count_q)) ? count_q + WIDTH'(1) : count_q;
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/stereo_op_scheduler.sv
// stereo_op_scheduler: time-shares one float operator across a left/right sample pair
module stereo_op_scheduler import audio_pkg::*; #(
  parameter int DATA_WIDTH     = AUDIO_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [DATA_WIDTH-1:0]     i_data_left,
  input  logic [DATA_WIDTH-1:0]     i_data_right,
  input  logic                      i_data_valid,
  output logic                      o_op_valid,
  output logic [DATA_WIDTH-1:0]     o_op_data,
  input  logic                      i_res_valid,
  input  logic [DATA_WIDTH-1:0]     i_res_data,
  output logic [DATA_WIDTH-1:0]     o_data_left,
  output logic [DATA_WIDTH-1:0]     o_data_right,
  output logic                      o_data_valid,
  output logic                      o_busy,
  output logic                      o_error,
  input  logic                      i_clear_error,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] op_data_q, op_data_d;
  logic [DATA_WIDTH-1:0] right_in_q, right_in_d;
  logic [DATA_WIDTH-1:0] cap_l_q, cap_l_d;
  logic [DATA_WIDTH-1:0] out_l_q, out_l_d;
  logic [DATA_WIDTH-1:0] out_r_q, out_r_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  error_q, error_d;
  logic                  waiting, timeout, drop;
  // sequencing: the left operand is loaded straight into the operand register on accept,
  // the right one is parked until ISSUE_L; results are taken in issue order
  always_comb begin
    waiting    = state_q == WAIT_L || state_q == WAIT_R;
    timeout    = waiting && !i_res_valid && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    drop       = i_data_valid && state_q != IDLE && state_q != DONE;
    error_d    = timeout || (error_q && !i_clear_error);
    state_d    = state_q;
    op_data_d  = op_data_q;
    right_in_d = right_in_q;
    cap_l_d    = cap_l_q;
    out_l_d    = out_l_q;
    out_r_d    = out_r_q;
    tmo_d      = waiting ? tmo_q + TW'(1) : '0;
    case (state_q)
      IDLE, DONE: begin
        state_d    = i_data_valid ? ISSUE_L : IDLE;
        op_data_d  = i_data_valid ? i_data_left : op_data_q;
        right_in_d = i_data_valid ? i_data_right : right_in_q;
      end
      ISSUE_L: begin
        state_d   = ISSUE_R;
        op_data_d = right_in_q;
      end
      ISSUE_R: begin
        state_d = i_res_valid ? WAIT_R : WAIT_L;
        cap_l_d = i_res_valid ? i_res_data : cap_l_q;
      end
      WAIT_L: begin
        state_d = i_res_valid ? WAIT_R : timeout ? IDLE : WAIT_L;
        cap_l_d = i_res_valid ? i_res_data : cap_l_q;
        tmo_d   = i_res_valid ? '0 : tmo_q + TW'(1);
      end
      WAIT_R: begin
        state_d = i_res_valid ? DONE : timeout ? IDLE : WAIT_R;
        out_l_d = i_res_valid ? cap_l_q : out_l_q;
        out_r_d = i_res_valid ? i_res_data : out_r_q;
        tmo_d   = i_res_valid ? '0 : tmo_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // state, data and status registers
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state_q    <= IDLE;
      op_data_q  <= '0;
      right_in_q <= '0;
      cap_l_q    <= '0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      tmo_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_data_q  <= op_data_d;
      right_in_q <= right_in_d;
      cap_l_q    <= cap_l_d;
      out_l_q    <= out_l_d;
      out_r_q    <= out_r_d;
      tmo_q      <= tmo_d;
      error_q    <= error_d;
    end
  sat_counter #(.WIDTH(DROP_CNT_WIDTH)) u_drop_cnt (
    .clk      (i_clock),
    .rst      (i_reset),
    .increment(drop),
    .count    (o_drop_count)
  );
  assign o_op_valid   = state_q == ISSUE_L || state_q == ISSUE_R;
  assign o_op_data    = op_data_q;
  assign o_data_left  = out_l_q;
  assign o_data_right = out_r_q;
  assign o_data_valid = state_q == DONE;
  assign o_busy       = state_q != IDLE;
  assign o_error      = error_q;
endmodule

// File: tb/tb_stereo_op_scheduler.sv
// tb_stereo_op_scheduler: directed checks of the stereo operator scheduler
module tb_stereo_op_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d_l = '0, d_r = '0;
  logic        d_v = 1'b0;
  logic        clr = 1'b0;
  logic        op_v, dv, busy, err;
  logic [31:0] op_d, o_l, o_r;
  logic        res_v;
  logic [31:0] res_d;
  logic [15:0] drops;
  logic        s_v = 1'b0;
  logic        s_op_v, s_dv, s_busy, s_err;
  logic [31:0] s_op_d, s_l, s_r;
  logic [3:0]  s_drops;
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, acc = 0, base = 0;
  int          op_lat = 4, op_lim = 0, iss_n = 0;
  logic [7:0]  pv = '0;
  logic [31:0] pd [8];
  logic        stray_v = 1'b0;
  logic [31:0] stray_d = '0;
  int          dv_n = 0, dv_cyc = 0;
  logic [31:0] dv_l = '0, dv_r = '0;

  stereo_op_scheduler dut (
    .i_clock(clk), .i_reset(rst), .i_data_left(d_l), .i_data_right(d_r), .i_data_valid(d_v),
    .o_op_valid(op_v), .o_op_data(op_d), .i_res_valid(res_v), .i_res_data(res_d),
    .o_data_left(o_l), .o_data_right(o_r), .o_data_valid(dv), .o_busy(busy), .o_error(err),
    .i_clear_error(clr), .o_drop_count(drops)
  );

  stereo_op_scheduler #(.TIMEOUT_CYCLES(4), .DROP_CNT_WIDTH(4)) dut_s (
    .i_clock(clk), .i_reset(rst), .i_data_left(d_l), .i_data_right(d_r), .i_data_valid(s_v),
    .o_op_valid(s_op_v), .o_op_data(s_op_d), .i_res_valid(1'b0), .i_res_data(32'h0),
    .o_data_left(s_l), .o_data_right(s_r), .o_data_valid(s_dv), .o_busy(s_busy), .o_error(s_err),
    .i_clear_error(clr), .o_drop_count(s_drops)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pv  <= {pv[6:0], op_v && iss_n < op_lim};
    pd[0] <= op_d;
    for (int i = 1; i < 8; i++) pd[i] <= pd[i-1];
    if (op_v) iss_n <= iss_n + 1;
  end

  always_comb begin
    res_v = pv[op_lat-1] | stray_v;
    res_d = stray_v ? stray_d : pd[op_lat-1];
  end

  always @(negedge clk)
    if (dv === 1'b1) begin
      dv_n   = dv_n + 1;
      dv_cyc = cyc;
      dv_l   = o_l;
      dv_r   = o_r;
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r);
    d_l = l;
    d_r = r;
    d_v = 1'b1;
    acc = cyc;
    step();
    d_v = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_opv", op_v, 0);
    chk("rst_dv", dv, 0);
    chk("rst_err", err, 0);
    chk("rst_drop", drops, 0);
    chk("rst_out", {o_l, o_r}, 0);
    chk("rst_opd", op_d, 0);
    rst = 1'b0;
    step();

    // echo operator, latency 4
    op_lat = 4;
    op_lim = iss_n + 2;
    base = dv_n;
    send(32'h3F800000, 32'h40000000);
    chk("t1_il_v", op_v, 1);
    chk("t1_il_d", op_d, 32'h3F800000);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_ir_v", op_v, 1);
    chk("t1_ir_d", op_d, 32'h40000000);
    step();
    chk("t1_wait_v", op_v, 0);
    chk("t1_hold_d", op_d, 32'h40000000);
    repeat (8) step();
    chk("t1_count", dv_n - base, 1);
    chk("t1_lat", dv_cyc - acc, 7);
    chk("t1_left", dv_l, 32'h3F800000);
    chk("t1_right", dv_r, 32'h40000000);
    chk("t1_idle", busy, 0);
    chk("t1_hold_out", {o_l, o_r}, {32'h3F800000, 32'h40000000});

    // second pair two cycles after the first is dropped
    op_lim = iss_n + 2;
    base = dv_n;
    send(32'h40400000, 32'h40800000);
    step();
    d_l = 32'hAAAA5555;
    d_r = 32'h5555AAAA;
    d_v = 1'b1;
    step();
    d_v = 1'b0;
    repeat (10) step();
    chk("t2_drop", drops, 1);
    chk("t2_count", dv_n - base, 1);
    chk("t2_left", dv_l, 32'h40400000);
    chk("t2_right", dv_r, 32'h40800000);

    // latency-1 operator: left result lands during ISSUE_R
    op_lat = 1;
    op_lim = iss_n + 4;
    base = dv_n;
    send(32'h11111111, 32'h22222222);
    repeat (3) step();
    chk("t3_dv", dv, 1);
    chk("t3_lat", dv_cyc - acc, 4);
    chk("t3_left", o_l, 32'h11111111);
    chk("t3_right", o_r, 32'h22222222);
    send(32'h33333333, 32'h44444444);
    repeat (7) step();
    chk("t3_count", dv_n - base, 2);
    chk("t3_b2b_lat", dv_cyc - acc, 4);
    chk("t3_b2b_left", dv_l, 32'h33333333);
    chk("t3_b2b_right", dv_r, 32'h44444444);
    chk("t3_nodrop", drops, 1);

    // only one result returns: timeout after 64 cycles in WAIT_R, clear held high loses
    op_lat = 4;
    op_lim = iss_n + 1;
    base = dv_n;
    clr = 1'b1;
    send(32'h55555555, 32'h66666666);
    repeat (68) step();
    chk("t4_pre_err", err, 0);
    chk("t4_pre_busy", busy, 1);
    step();
    chk("t4_err", err, 1);
    chk("t4_idle", busy, 0);
    clr = 1'b0;
    step();
    chk("t4_sticky", err, 1);
    chk("t4_no_dv", dv_n - base, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_clear", err, 0);

    // reset during WAIT_L, then late and stray results
    op_lim = iss_n + 2;
    base = dv_n;
    send(32'h77777777, 32'h88888888);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    repeat (4) step();
    stray_d = 32'h12345678;
    stray_v = 1'b1;
    step();
    stray_v = 1'b0;
    repeat (2) step();
    chk("t5_no_dv", dv_n - base, 0);
    chk("t5_err", err, 0);
    chk("t5_busy", busy, 0);
    chk("t5_opv", op_v, 0);
    chk("t5_out", {o_l, o_r}, 0);
    chk("t5_opd", op_d, 0);
    chk("t5_drop", drops, 0);

    // drop counter saturation on the narrow instance
    s_v = 1'b1;
    repeat (4) step();
    chk("t6_partial", s_drops, 3);
    repeat (40) step();
    chk("t6_sat", s_drops, 4'hF);
    repeat (8) step();
    chk("t6_stay", s_drops, 4'hF);
    s_v = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stereo_op_scheduler.md
STEREO_OP_SCHEDULER -- requirements
Module: stereo_op_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, float sample width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum wait cycles for a result.
REQ-003 SHALL have parameter DROP_CNT_WIDTH, default 16, width of the dropped-sample counter.
REQ-004 SHALL have port i_clock  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port i_reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports i_data_left/i_data_right  in  DATA_WIDTH  stereo input sample pair.
REQ-007 SHALL have port i_data_valid  in  1  one-cycle pulse qualifying the input pair.
REQ-008 SHALL have port o_op_valid  out  1  issue strobe to the shared float operator.
REQ-009 SHALL have port o_op_data  out  DATA_WIDTH  operand to the shared operator.
REQ-010 SHALL have port i_res_valid  in  1  result strobe from the operator; results return in issue order.
REQ-011 SHALL have port i_res_data  in  DATA_WIDTH  operator result.
REQ-012 SHALL have ports o_data_left/o_data_right  out  DATA_WIDTH  processed stereo pair.
REQ-013 SHALL have port o_data_valid  out  1  one-cycle pulse qualifying the output pair.
REQ-014 SHALL have port o_busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port o_error  out  1  sticky timeout flag.
REQ-016 SHALL have port i_clear_error  in  1  synchronous clear of o_error.
REQ-017 SHALL have port o_drop_count  out  DROP_CNT_WIDTH  count of rejected input pairs.

Function
REQ-018 SHALL implement states IDLE, ISSUE_L, ISSUE_R, WAIT_L, WAIT_R, DONE.
REQ-019 SHALL accept i_data_valid only in IDLE or DONE: register both samples, go to ISSUE_L.
REQ-020 ISSUE_L SHALL drive o_op_valid=1 with the left sample for exactly one cycle, then go to ISSUE_R.
REQ-021 ISSUE_R SHALL drive o_op_valid=1 with the right sample for exactly one cycle, then go to WAIT_L, or to WAIT_R when the left result arrived during ISSUE_R.
REQ-022 The first i_res_valid after the left issue SHALL be captured as left; the second SHALL be captured as right.
REQ-023 A result arriving in ISSUE_R (operator latency 1) SHALL be captured as left.
REQ-024 After the right result is captured the block SHALL go to DONE; DONE SHALL pulse o_data_valid for one cycle with both captured results, then go to IDLE unless a new pair is accepted.
REQ-025 Latency SHALL be operator latency L plus 3 cycles, from the accept cycle to the o_data_valid cycle.
REQ-026 o_op_valid SHALL be 0 and o_op_data SHALL hold its last value outside ISSUE_L/ISSUE_R.
REQ-027 i_data_valid in ISSUE_L/ISSUE_R/WAIT_L/WAIT_R SHALL be discarded and SHALL increment o_drop_count, saturating at all-ones.
REQ-028 The timeout counter SHALL clear on entry to WAIT_L and on each captured result, and SHALL increment each cycle in WAIT_L/WAIT_R.
REQ-029 When the counter reaches TIMEOUT_CYCLES, the block SHALL set o_error, return to IDLE and produce no o_data_valid.
REQ-030 i_res_valid in IDLE or DONE SHALL be ignored without error.
REQ-031 If i_clear_error and a timeout occur in the same cycle, the timeout SHALL win (o_error=1).
REQ-032 o_data_left/o_data_right SHALL hold their values until the next DONE.

Reset
REQ-033 Reset SHALL force IDLE, o_op_valid=0, o_data_valid=0, o_busy=0, o_error=0, o_drop_count=0, all data registers=0 and the timeout counter=0.
REQ-034 Reset asserted mid-operation SHALL abandon the pair with no output pulse; late results after release SHALL be ignored per REQ-030.

Structure
REQ-035 The state enum type and the default DATA_WIDTH SHALL be defined in the shared package audio_pkg.
REQ-036 The drop counter SHALL be a sub-module sat_counter (parameter WIDTH; ports increment, count).

Verification
REQ-037 Left 0x3F800000 and right 0x40000000 with an operator of L=4 that echoes its operand -> exactly one o_data_valid, 7 cycles after accept, with left=0x3F800000 and right=0x40000000.
REQ-038 A second i_data_valid 2 cycles after the first -> o_drop_count=1 and only the first pair is output.
REQ-039 Operator L=1 -> the result arriving in ISSUE_R is captured as left, with correct ordering at the output.
REQ-040 Operator returning only one result -> after 64 cycles in WAIT_R, o_error=1, IDLE, no o_data_valid; i_clear_error -> o_error=0.
REQ-041 Reset pulsed during WAIT_L followed by stray i_res_valid -> all outputs 0, no o_data_valid, no o_error.
REQ-042 Drop counter forced to 0xFFFF plus one more rejected pair -> o_drop_count stays 0xFFFF.
